// File: rtl/rob_dispatch_if.sv
// Instruction-queue / reservation-station / ALU / regfile signal bundle for rob_dispatch.
interface rob_dispatch_if #(
  parameter int TagWidth = 4
);
  // Instruction queue side
  logic                in_valid;
  logic [5:0]          in_op;
  logic [4:0]          in_rd;
  logic [4:0]          in_rs1;
  logic [4:0]          in_rs2;
  logic [31:0]         in_imm;
  logic [31:0]         in_pc;
  logic                in_is_sl;
  logic                stall_to_iq;

  // Register file read data for in_rs1/in_rs2
  logic [31:0]         rs1_val;
  logic [31:0]         rs2_val;

  // Reservation station side
  logic                is_stall_from_rs;
  logic                is_empty_to_rs;
  logic                is_sl_to_rs;
  logic [5:0]          op_to_rs;
  logic [31:0]         v1_to_rs;
  logic [31:0]         v2_to_rs;
  logic [31:0]         q1_to_rs;
  logic [31:0]         q2_to_rs;
  logic [31:0]         imm_to_rs;
  logic [31:0]         pc_to_rs;
  logic                is_commit_to_rs;
  logic [31:0]         commit_pc_to_rs;
  logic [31:0]         commit_data_to_rs;
  logic                is_exception_to_rs;
  logic [31:0]         flush_pc;

  // ALU writeback
  logic                alu_valid;
  logic [TagWidth-1:0] alu_tag;
  logic [31:0]         alu_data;
  logic                alu_mispredict;
  logic [31:0]         alu_target;

  // Register file write
  logic                rf_we;
  logic [4:0]          rf_rd;
  logic [31:0]         rf_data;

  // The ROB itself
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, in_is_sl,
    input  rs1_val, rs2_val, is_stall_from_rs,
    input  alu_valid, alu_tag, alu_data, alu_mispredict, alu_target,
    output stall_to_iq, is_empty_to_rs, is_sl_to_rs, op_to_rs,
    output v1_to_rs, v2_to_rs, q1_to_rs, q2_to_rs, imm_to_rs, pc_to_rs,
    output is_commit_to_rs, commit_pc_to_rs, commit_data_to_rs,
    output rf_we, rf_rd, rf_data, is_exception_to_rs, flush_pc
  );

  // The surrounding core driving the ROB
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, in_is_sl,
    output rs1_val, rs2_val, is_stall_from_rs,
    output alu_valid, alu_tag, alu_data, alu_mispredict, alu_target,
    input  stall_to_iq, is_empty_to_rs, is_sl_to_rs, op_to_rs,
    input  v1_to_rs, v2_to_rs, q1_to_rs, q2_to_rs, imm_to_rs, pc_to_rs,
    input  is_commit_to_rs, commit_pc_to_rs, commit_data_to_rs,
    input  rf_we, rf_rd, rf_data, is_exception_to_rs, flush_pc
  );
endinterface

// File: rtl/rob_dispatch.sv
// In-order reorder buffer with rename/dispatch front end. Tags are entry index + 1,
// tag 0 means "value is architectural". Commits one entry per cycle from the head and
// flushes everything when a mispredicted branch commits.
module rob_dispatch #(
  parameter int RobDepth = 8,
  parameter int TagWidth = 4
) (
  input logic           clk,
  input logic           rst,
  rob_dispatch_if.slave bus
);

  localparam int IdxW = (RobDepth > 1) ? $clog2(RobDepth) : 1;
  localparam int CntW = IdxW + 1;

  typedef struct packed {
    logic [31:0]         v;
    logic [TagWidth-1:0] q;
  } opnd_t;

  function automatic logic [TagWidth-1:0] idx_to_tag(input logic [IdxW-1:0] idx);
    return TagWidth'(idx) + TagWidth'(1);
  endfunction

  function automatic logic [IdxW-1:0] tag_to_idx(input logic [TagWidth-1:0] tag);
    return IdxW'(tag - TagWidth'(1));
  endfunction

  // Priority: x0, architectural value, completed entry, same-cycle ALU bypass, wait on tag.
  function automatic opnd_t resolve(input logic [4:0]          rs,
                                    input logic [TagWidth-1:0] tag,
                                    input logic [31:0]         rf_val,
                                    input logic                tag_ready,
                                    input logic [31:0]         tag_data,
                                    input logic                byp_hit,
                                    input logic [31:0]         byp_data);
    opnd_t r;
    r.v = '0;
    r.q = '0;
    if (rs != 5'd0) begin
      if (tag == '0)      r.v = rf_val;
      else if (tag_ready) r.v = tag_data;
      else if (byp_hit)   r.v = byp_data;
      else                r.q = tag;
    end
    return r;
  endfunction

  // ROB control state
  logic [IdxW-1:0]     head;
  logic [IdxW-1:0]     tail;
  logic [CntW-1:0]     count;
  logic [RobDepth-1:0] ent_valid;
  logic [RobDepth-1:0] ent_ready;
  logic [RobDepth-1:0] ent_mispred;
  logic [TagWidth-1:0] reg_tag [32];

  // ROB payload (qualified by ent_valid/ent_ready, so never reset)
  logic [4:0]          ent_rd     [RobDepth];
  logic [31:0]         ent_data   [RobDepth];
  logic [31:0]         ent_target [RobDepth];

  logic [TagWidth-1:0] head_tag;
  logic [TagWidth-1:0] tail_tag;
  logic                head_commit;
  logic                flush;
  logic                accept;
  logic [IdxW-1:0]     wb_idx;
  logic                wb_hit;
  logic [TagWidth-1:0] src1_tag;
  logic [TagWidth-1:0] src2_tag;
  logic [IdxW-1:0]     src1_idx;
  logic [IdxW-1:0]     src2_idx;
  opnd_t               opnd1;
  opnd_t               opnd2;

  // ---- stage p0: accept, rename lookup, commit selection ----
  assign head_tag    = idx_to_tag(head);
  assign tail_tag    = idx_to_tag(tail);
  assign head_commit = ent_valid[head] & ent_ready[head];
  assign flush       = head_commit & ent_mispred[head];

  // Stall looks only at the registered count, so a full ROB refuses even while committing.
  assign bus.stall_to_iq = (count == CntW'(RobDepth)) | bus.is_stall_from_rs;
  assign accept          = bus.in_valid & ~bus.stall_to_iq & ~flush;

  assign wb_idx = tag_to_idx(bus.alu_tag);
  assign wb_hit = bus.alu_valid && (bus.alu_tag != '0) &&
                  (bus.alu_tag <= TagWidth'(RobDepth)) && ent_valid[wb_idx];

  assign src1_tag = reg_tag[bus.in_rs1];
  assign src2_tag = reg_tag[bus.in_rs2];
  assign src1_idx = tag_to_idx(src1_tag);
  assign src2_idx = tag_to_idx(src2_tag);

  assign opnd1 = resolve(bus.in_rs1, src1_tag, bus.rs1_val, ent_ready[src1_idx],
                         ent_data[src1_idx], bus.alu_valid && (bus.alu_tag == src1_tag),
                         bus.alu_data);
  assign opnd2 = resolve(bus.in_rs2, src2_tag, bus.rs2_val, ent_ready[src2_idx],
                         ent_data[src2_idx], bus.alu_valid && (bus.alu_tag == src2_tag),
                         bus.alu_data);

  // Commit broadcast comes straight from the head entry, so the regfile write and
  // the reg_tag clear land on the same edge.
  assign bus.is_commit_to_rs    = head_commit;
  assign bus.commit_pc_to_rs    = head_commit ? 32'(head_tag) : '0;
  assign bus.commit_data_to_rs  = head_commit ? ent_data[head] : '0;
  assign bus.rf_we              = head_commit && (ent_rd[head] != 5'd0);
  assign bus.rf_rd              = head_commit ? ent_rd[head] : '0;
  assign bus.rf_data            = head_commit ? ent_data[head] : '0;
  assign bus.is_exception_to_rs = flush;
  assign bus.flush_pc           = flush ? ent_target[head] : '0;

  // Pointer, occupancy, entry status and rename table; a flush wipes all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ent_valid   <= '0;
      ent_ready   <= '0;
      ent_mispred <= '0;
      for (int r = 0; r < 32; r++) reg_tag[r] <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      ent_valid   <= '0;
      ent_ready   <= '0;
      ent_mispred <= '0;
      for (int r = 0; r < 32; r++) reg_tag[r] <= '0;
    end else begin
      if (wb_hit) begin
        ent_ready[wb_idx]   <= 1'b1;
        ent_mispred[wb_idx] <= bus.alu_mispredict;
      end
      if (head_commit) begin
        ent_valid[head]   <= 1'b0;
        ent_ready[head]   <= 1'b0;
        ent_mispred[head] <= 1'b0;
        head              <= head + IdxW'(1);
        if ((ent_rd[head] != 5'd0) && (reg_tag[ent_rd[head]] == head_tag))
          reg_tag[ent_rd[head]] <= '0;
      end
      // Placed after the commit clear so a rename of the same rd takes precedence.
      if (accept) begin
        ent_valid[tail]   <= 1'b1;
        ent_ready[tail]   <= 1'b0;
        ent_mispred[tail] <= 1'b0;
        tail              <= tail + IdxW'(1);
        if (bus.in_rd != 5'd0) reg_tag[bus.in_rd] <= tail_tag;
      end
      count <= count + CntW'(accept) - CntW'(head_commit);
    end
  end

  // Entry payload capture: destination at allocation, result/target at writeback.
  always_ff @(posedge clk) begin
    if (!flush && wb_hit) begin
      ent_data[wb_idx]   <= bus.alu_data;
      ent_target[wb_idx] <= bus.alu_target;
    end
    if (accept) ent_rd[tail] <= bus.in_rd;
  end

  // ---- stage p1: registered dispatch to the reservation station ----
  logic                vld_p1;
  logic                sl_p1;
  logic [5:0]          op_p1;
  logic [31:0]         v1_p1;
  logic [31:0]         v2_p1;
  logic [TagWidth-1:0] q1_p1;
  logic [TagWidth-1:0] q2_p1;
  logic [31:0]         imm_p1;
  logic [31:0]         pc_p1;

  // Dispatch valid: high for exactly the cycle after an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  // Dispatch payload, captured only on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      sl_p1  <= bus.in_is_sl;
      op_p1  <= bus.in_op;
      v1_p1  <= opnd1.v;
      v2_p1  <= opnd2.v;
      q1_p1  <= opnd1.q;
      q2_p1  <= opnd2.q;
      imm_p1 <= bus.in_imm;
      pc_p1  <= bus.in_pc;
    end
  end

  // Outputs are gated by the valid so idle and reset cycles present zeros.
  assign bus.is_empty_to_rs = ~vld_p1;
  assign bus.is_sl_to_rs    = vld_p1 & sl_p1;
  assign bus.op_to_rs       = vld_p1 ? op_p1 : '0;
  assign bus.v1_to_rs       = vld_p1 ? v1_p1 : '0;
  assign bus.v2_to_rs       = vld_p1 ? v2_p1 : '0;
  assign bus.q1_to_rs       = vld_p1 ? 32'(q1_p1) : '0;
  assign bus.q2_to_rs       = vld_p1 ? 32'(q2_p1) : '0;
  assign bus.imm_to_rs      = vld_p1 ? imm_p1 : '0;
  assign bus.pc_to_rs       = vld_p1 ? pc_p1 : '0;

endmodule

// File: tb/tb_rob_dispatch.sv
// Scoreboard bench for rob_dispatch: stimulus pushes expected dispatches and commits,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_rob_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_dispatch_if #(.TagWidth(4)) bus ();

  rob_dispatch #(.RobDepth(8), .TagWidth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, q1, v2, q2, imm, pc;
    logic        sl;
  } disp_t;

  typedef struct {
    logic [31:0] tag, data;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] fpc;
  } cmt_t;

  disp_t dq[$];
  cmt_t  cq[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every dispatch and commit the DUT presents against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.is_empty_to_rs) begin : mon_disp
        disp_t e;
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_dispatch: got op 0x%0h pc 0x%0h, expected none",
                   bus.op_to_rs, bus.pc_to_rs);
        end else begin
          e = dq.pop_front();
          chk("disp_op",  32'(bus.op_to_rs), 32'(e.op));
          chk("disp_v1",  bus.v1_to_rs,  e.v1);
          chk("disp_q1",  bus.q1_to_rs,  e.q1);
          chk("disp_v2",  bus.v2_to_rs,  e.v2);
          chk("disp_q2",  bus.q2_to_rs,  e.q2);
          chk("disp_imm", bus.imm_to_rs, e.imm);
          chk("disp_pc",  bus.pc_to_rs,  e.pc);
          chk("disp_sl",  32'(bus.is_sl_to_rs), 32'(e.sl));
        end
      end
      if (bus.is_commit_to_rs) begin : mon_cmt
        cmt_t c;
        if (cq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_commit: got tag %0d data 0x%0h, expected none",
                   bus.commit_pc_to_rs, bus.commit_data_to_rs);
        end else begin
          c = cq.pop_front();
          chk("commit_tag",  bus.commit_pc_to_rs,   c.tag);
          chk("commit_data", bus.commit_data_to_rs, c.data);
          chk("rf_we",       32'(bus.rf_we),        32'(c.rd != 5'd0));
          chk("rf_rd",       32'(bus.rf_rd),        32'(c.rd));
          chk("rf_data",     bus.rf_data,           c.data);
          chk("exception",   32'(bus.is_exception_to_rs), 32'(c.exc));
          chk("flush_pc",    bus.flush_pc,          c.fpc);
        end
      end else if (bus.is_exception_to_rs) begin
        tests++; fails++;
        $display("FAIL exception_without_commit: got 1, expected 0");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic put_wb(input logic [3:0] tag, input logic [31:0] data,
                        input logic misp, input logic [31:0] tgt);
    bus.alu_valid      = 1'b1;
    bus.alu_tag        = tag;
    bus.alu_data       = data;
    bus.alu_mispredict = misp;
    bus.alu_target     = tgt;
  endtask

  task automatic clear_inputs();
    bus.in_valid       = 1'b0;
    bus.alu_valid      = 1'b0;
    bus.alu_mispredict = 1'b0;
  endtask

  task automatic wb_only(input logic [3:0] tag, input logic [31:0] data,
                         input logic misp, input logic [31:0] tgt);
    put_wb(tag, data, misp, tgt);
    step();
    clear_inputs();
  endtask

  task automatic put_instr(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                           input logic [31:0] r1v, input logic [31:0] r2v, input logic sl);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.in_pc    = pc;
    bus.rs1_val  = r1v;
    bus.rs2_val  = r2v;
    bus.in_is_sl = sl;
  endtask

  // Present one instruction, record its expected dispatch, and clock it in.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                      input logic [31:0] r1v, input logic [31:0] r2v,
                      input logic [31:0] ev1, input logic [31:0] eq1,
                      input logic [31:0] ev2, input logic [31:0] eq2, input logic sl);
    disp_t e;
    put_instr(op, rd, rs1, rs2, imm, pc, r1v, r2v, sl);
    e = '{op: op, v1: ev1, q1: eq1, v2: ev2, q2: eq2, imm: imm, pc: pc, sl: sl};
    dq.push_back(e);
    chk("stall_before_send", 32'(bus.stall_to_iq), 32'd0);
    step();
    clear_inputs();
  endtask

  task automatic exp_commit(input logic [31:0] tag, input logic [31:0] data, input logic [4:0] rd,
                            input logic exc, input logic [31:0] fpc);
    cmt_t c;
    c = '{tag: tag, data: data, rd: rd, exc: exc, fpc: fpc};
    cq.push_back(c);
  endtask

  task automatic drained(input string phase);
    chk({phase, "_dispatch_queue_empty"}, dq.size(), 32'd0);
    chk({phase, "_commit_queue_empty"},   cq.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dq.delete();
    cq.delete();
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_imm = 0; bus.in_pc = 0; bus.in_is_sl = 0; bus.rs1_val = 0; bus.rs2_val = 0;
    bus.is_stall_from_rs = 0; bus.alu_valid = 0; bus.alu_tag = 0; bus.alu_data = 0;
    bus.alu_mispredict = 0; bus.alu_target = 0;

    // Reset state
    #12;
    chk("rst_empty",     32'(bus.is_empty_to_rs), 32'd1);
    chk("rst_stall",     32'(bus.stall_to_iq), 32'd0);
    chk("rst_commit",    32'(bus.is_commit_to_rs), 32'd0);
    chk("rst_rf_we",     32'(bus.rf_we), 32'd0);
    chk("rst_exception", 32'(bus.is_exception_to_rs), 32'd0);
    chk("rst_op",        32'(bus.op_to_rs), 32'd0);
    chk("rst_v1",        bus.v1_to_rs, 32'd0);
    chk("rst_flush_pc",  bus.flush_pc, 32'd0);
    step();
    rst = 1'b0;

    // ADDI x1,x0,5 then dependent use of x1; results written back in order.
    send(6'h13, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100, 32'hdead, 32'hbeef, 0, 0, 0, 0, 1'b0);
    send(6'h33, 5'd2, 5'd1, 5'd0, 32'd0, 32'h104, 32'h1111, 32'h0, 0, 1, 0, 0, 1'b0);
    exp_commit(1, 32'd7, 5'd1, 1'b0, 0);
    wb_only(4'd1, 32'd7, 1'b0, 0);
    exp_commit(2, 32'h70, 5'd2, 1'b0, 0);
    wb_only(4'd2, 32'h70, 1'b0, 0);
    idle(3);
    drained("dep");

    // Same-cycle ALU bypass, then completed-entry read.
    do_reset();
    send(6'h13, 5'd1, 5'd0, 5'd0, 32'd1, 32'h200, 0, 0, 0, 0, 0, 0, 1'b0);
    send(6'h13, 5'd2, 5'd0, 5'd0, 32'd2, 32'h204, 0, 0, 0, 0, 0, 0, 1'b0);
    put_wb(4'd2, 32'h55, 1'b0, 0);
    send(6'h33, 5'd3, 5'd2, 5'd1, 32'd0, 32'h208, 32'haaaa, 32'hbbbb, 32'h55, 0, 0, 1, 1'b0);
    send(6'h33, 5'd0, 5'd2, 5'd0, 32'd0, 32'h20c, 32'hcccc, 0, 32'h55, 0, 0, 0, 1'b0);
    exp_commit(1, 32'h11, 5'd1, 1'b0, 0);
    exp_commit(2, 32'h55, 5'd2, 1'b0, 0);
    exp_commit(3, 32'h33, 5'd3, 1'b0, 0);
    exp_commit(4, 32'h44, 5'd0, 1'b0, 0);
    wb_only(4'd1, 32'h11, 1'b0, 0);
    wb_only(4'd3, 32'h33, 1'b0, 0);
    wb_only(4'd4, 32'h44, 1'b0, 0);
    idle(4);
    drained("bypass");

    // Out-of-order writeback 3,2,1 commits 1,2,3 on consecutive cycles.
    do_reset();
    send(6'h13, 5'd1, 5'd0, 5'd0, 32'd1, 32'h300, 0, 0, 0, 0, 0, 0, 1'b0);
    send(6'h03, 5'd2, 5'd0, 5'd0, 32'd2, 32'h304, 0, 0, 0, 0, 0, 0, 1'b1);
    send(6'h13, 5'd3, 5'd0, 5'd0, 32'd3, 32'h308, 0, 0, 0, 0, 0, 0, 1'b0);
    exp_commit(1, 32'h111, 5'd1, 1'b0, 0);
    exp_commit(2, 32'h222, 5'd2, 1'b0, 0);
    exp_commit(3, 32'h333, 5'd3, 1'b0, 0);
    wb_only(4'd3, 32'h333, 1'b0, 0);
    wb_only(4'd2, 32'h222, 1'b0, 0);
    chk("ooo_no_early_commit", 32'(bus.is_commit_to_rs), 32'd0);
    wb_only(4'd1, 32'h111, 1'b0, 0);
    chk("ooo_seq1", bus.commit_pc_to_rs, 32'd1);
    step();
    chk("ooo_seq2", bus.commit_pc_to_rs, 32'd2);
    step();
    chk("ooo_seq3", bus.commit_pc_to_rs, 32'd3);
    idle(3);
    drained("ooo");

    // Fill all 8 entries, hold a 9th, free the head, then the 9th takes tag 1.
    do_reset();
    for (int i = 0; i < 8; i++)
      send(6'h13, 5'(i + 1), 5'd0, 5'd0, 32'(i), 32'h400 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 1'b0);
    chk("full_stall", 32'(bus.stall_to_iq), 32'd1);
    put_instr(6'h13, 5'd9, 5'd1, 5'd0, 32'd9, 32'h420, 32'h99, 0, 1'b0);
    exp_commit(1, 32'h99, 5'd1, 1'b0, 0);
    put_wb(4'd1, 32'h99, 1'b0, 0);
    step();
    bus.alu_valid = 1'b0;
    chk("full_commit_still_stall", 32'(bus.stall_to_iq), 32'd1);
    step();
    chk("stall_released", 32'(bus.stall_to_iq), 32'd0);
    dq.push_back('{op: 6'h13, v1: 32'h99, q1: 0, v2: 0, q2: 0, imm: 32'd9, pc: 32'h420, sl: 1'b0});
    step();
    clear_inputs();
    chk("refull_stall", 32'(bus.stall_to_iq), 32'd1);
    for (int t = 2; t <= 8; t++) exp_commit(32'(t), 32'h40 + 32'(t), 5'(t), 1'b0, 0);
    exp_commit(1, 32'h909, 5'd9, 1'b0, 0);
    for (int t = 2; t <= 8; t++) wb_only(4'(t), 32'h40 + 32'(t), 1'b0, 0);
    wb_only(4'd1, 32'h909, 1'b0, 0);
    idle(4);
    drained("wrap");

    // Mispredict on tag 1: flush, suppressed accept, stale writeback ignored.
    do_reset();
    send(6'h63, 5'd1, 5'd0, 5'd0, 32'h100, 32'h100, 0, 0, 0, 0, 0, 0, 1'b0);
    send(6'h33, 5'd2, 5'd1, 5'd0, 32'd0, 32'h104, 32'h1234, 0, 0, 1, 0, 0, 1'b0);
    exp_commit(1, 32'h1, 5'd1, 1'b1, 32'h200);
    wb_only(4'd1, 32'h1, 1'b1, 32'h200);
    chk("misp_exception", 32'(bus.is_exception_to_rs), 32'd1);
    chk("misp_flush_pc",  bus.flush_pc, 32'h200);
    put_instr(6'h33, 5'd3, 5'd1, 5'd0, 32'd0, 32'h108, 0, 0, 1'b0);
    step();
    clear_inputs();
    wb_only(4'd2, 32'hbad, 1'b0, 0);
    send(6'h33, 5'd0, 5'd1, 5'd2, 32'd0, 32'h200, 32'ha1, 32'ha2, 32'ha1, 0, 32'ha2, 0, 1'b0);
    exp_commit(1, 32'h5, 5'd0, 1'b0, 0);
    wb_only(4'd1, 32'h5, 1'b0, 0);
    idle(3);
    drained("flush");

    // Asynchronous reset mid-operation returns outputs to reset values at once.
    do_reset();
    for (int i = 0; i < 8; i++)
      send(6'h13, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1), 32'h500 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 1'b0);
    chk("pre_reset_stall",    32'(bus.stall_to_iq), 32'd1);
    chk("pre_reset_dispatch", 32'(bus.is_empty_to_rs), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_empty",     32'(bus.is_empty_to_rs), 32'd1);
    chk("midrst_stall",     32'(bus.stall_to_iq), 32'd0);
    chk("midrst_op",        32'(bus.op_to_rs), 32'd0);
    chk("midrst_imm",       bus.imm_to_rs, 32'd0);
    chk("midrst_pc",        bus.pc_to_rs, 32'd0);
    chk("midrst_commit",    32'(bus.is_commit_to_rs), 32'd0);
    chk("midrst_rf_we",     32'(bus.rf_we), 32'd0);
    chk("midrst_exception", 32'(bus.is_exception_to_rs), 32'd0);
    dq.delete();
    cq.delete();
    step();
    rst = 1'b0;
    send(6'h13, 5'd5, 5'd1, 5'd0, 32'd0, 32'h600, 32'h77, 0, 32'h77, 0, 0, 0, 1'b0);
    idle(2);
    drained("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_dispatch.md
Name: rob_dispatch

Overview:
- In-order reorder buffer and dispatch front end for the out-of-order core.
- Accepts decoded instructions from the instruction queue and renames source operands through a register-status table.
- Sends op, v1/v2, q1/q2, imm and pc to the reservation station, and collects ALU results.
- Retires in program order, broadcasting each commit to the RS and register file, and issues a flush on branch mispredict.

Parameters:
RobDepth, 8, number of ROB entries; power of two, 2..16.
TagWidth, 4, tag bits = log2(RobDepth)+1; tag = entry index+1; tag 0 means "value ready".

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  instruction queue presents an instruction
in_op / in_rd / in_rs1 / in_rs2  in  6/5/5/5  opcode and register indices
in_imm / in_pc  in  32/32  immediate and pc
in_is_sl  in  1  load/store (routed to the LSB, not the ALU RS)
rs1_val / rs2_val  in  32/32  combinational regfile read data for in_rs1/in_rs2
is_stall_from_rs  in  1  RS full
alu_valid / alu_tag / alu_data  in  1/TagWidth/32  ALU result writeback
alu_mispredict / alu_target  in  1/32  result is a mispredicted branch; correct pc
stall_to_iq  out  1  instruction not accepted this cycle
is_empty_to_rs  out  1  1 = no dispatch this cycle
is_sl_to_rs  out  1  dispatched entry is load/store
op_to_rs  out  6
v1_to_rs / v2_to_rs  out  32/32
q1_to_rs / q2_to_rs  out  32/32  zero-extended source tags
imm_to_rs / pc_to_rs  out  32/32
is_commit_to_rs  out  1  one-cycle commit pulse
commit_pc_to_rs  out  32  zero-extended tag of the committing entry
commit_data_to_rs  out  32
rf_we / rf_rd / rf_data  out  1/5/32  register file write
is_exception_to_rs  out  1  flush pulse
flush_pc  out  32  redirect target, valid with is_exception_to_rs

Behaviour:
- Reset (async, active-high):
  - head=tail=count=0; all entries invalid; reg_tag[0..31]=0.
  - is_empty_to_rs=1; all other outputs 0.
- Accept:
  - stall_to_iq = (count==RobDepth) | is_stall_from_rs, combinational.
  - An instruction is accepted on a clk edge when in_valid & !stall_to_iq.
  - The accepted instruction is written at tail; tail wraps modulo RobDepth; count increments.
- Dispatch:
  - RS outputs are registered and appear the cycle after accept, with is_empty_to_rs=0 for exactly that one cycle.
  - No accept in a cycle gives is_empty_to_rs=1 next cycle.
- Operand resolution (per source, at accept):
  - Index 0: v=0, q=0.
  - reg_tag==0: v=rsN_val, q=0.
  - Entry reg_tag is ready: v=entry data, q=0.
  - alu_valid & alu_tag==reg_tag in the same cycle: v=alu_data, q=0 (bypass).
  - Otherwise: v=0, q=reg_tag.
- Rename: if in_rd!=0, reg_tag[in_rd]=new tag. Sources are resolved before the rename, so rd==rs reads the old mapping.
- Writeback: when alu_valid, the entry alu_tag is marked ready with data; mispredict flag and target are stored with it.
- Commit:
  - When the head entry is valid and ready, pulse is_commit_to_rs, commit_pc_to_rs=head tag and commit_data_to_rs=data for one cycle.
  - In the same cycle drive rf_we=(rd!=0), rf_rd and rf_data.
  - Free head; head++; count--.
  - Clear reg_tag[rd] only if it still equals the head tag.
  - Maximum one commit per cycle.
- Simultaneous events:
  - Accept and commit in one cycle: count unchanged.
  - Full and committing: accept still refused that cycle (stall uses registered count).
  - Rename and commit-clear of the same rd: rename wins.
- Mispredict:
  - Committing an entry with mispredict set pulses is_exception_to_rs=1 and flush_pc=target alongside the commit.
  - The next edge invalidates all entries, zeroes head/tail/count and reg_tag, and suppresses any accept in that cycle.
  - Writebacks to flushed tags are ignored.
- Tags are never reused while in flight, because an entry is freed only at commit.

Test Plan:
- Reset, then one ADDI rd=1 rs1=0 imm=5 pc=0x100 → next cycle is_empty_to_rs=0, v1=0, q1=0, imm=5, pc_to_rs=0x100; stall_to_iq=0.
- Dependent pair: x1←tag1, then rs1=1 → q1_to_rs=1. alu_valid tag1 data=7 → is_commit_to_rs, commit_pc_to_rs=1, commit_data=7, rf_we rd=1.
- Fill 8 entries with no writeback → stall_to_iq=1 and 9th held. Writeback tag1 → commit next cycle; 9th accepted the cycle after, with tail wrapped to index 0 and tag 1.
- Out-of-order writeback of tags 3,2,1 → commits in order 1,2,3 on consecutive cycles.
- Same-cycle bypass: dispatch rs1 mapped to tag2 while alu_valid tag2 data=0x55 → v1=0x55, q1=0.
- Mispredict on tag1 with target 0x200 → is_exception_to_rs=1, flush_pc=0x200; next cycle count=0, later sources read rsN_val with q=0.
- Assert rst mid-operation → all outputs return to reset values immediately.
